// File: rtl/regfile_wb_arbiter_if.sv
// Writeback bus between the execute-stage requesters and the regfile write
// arbiter. The master side is the requester cluster (and the regfile
// consumer); the slave side is the arbiter itself.
interface regfile_wb_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int PREG_W  = 6,
    parameter int DATA_W  = 64
) ();
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*PREG_W-1:0] req_idx;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        req_ready;
    logic                      write0_en;
    logic [PREG_W-1:0]         write0_idx;
    logic [DATA_W-1:0]         write0_data;
    logic                      write1_en;
    logic [PREG_W-1:0]         write1_idx;
    logic [DATA_W-1:0]         write1_data;
    logic [15:0]               conflict_cnt;

    modport master (
        output req_valid, req_idx, req_data,
        input  req_ready,
        input  write0_en, write0_idx, write0_data,
        input  write1_en, write1_idx, write1_data,
        input  conflict_cnt
    );

    modport slave (
        input  req_valid, req_idx, req_data,
        output req_ready,
        output write0_en, write0_idx, write0_data,
        output write1_en, write1_idx, write1_data,
        output conflict_cnt
    );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Regfile writeback arbiter: round-robin selection of up to two writers per
// cycle onto the two physical-regfile write ports. Writes to preg 0 are
// acknowledged without using a port. Chosen writes are registered, so the
// regfile sees them one cycle after acceptance.
module regfile_wb_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int PREG_W  = 6,
    parameter int DATA_W  = 64
) (
    input  logic                  clock,
    input  logic                  reset,
    regfile_wb_arbiter_if.slave   bus
);
    localparam int PTR_W = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1;

    logic [PTR_W-1:0]   rr_ptr_r;
    logic [PTR_W-1:0]   rr_ptr_nxt_s;
    logic [NUM_REQ-1:0] eligible_s;
    logic [NUM_REQ-1:0] null_s;
    logic [NUM_REQ-1:0] grant0_s;
    logic [NUM_REQ-1:0] grant1_s;
    logic               g0_found_s;
    logic               g1_found_s;
    logic [PREG_W-1:0]  g0_idx_s;
    logic [PREG_W-1:0]  g1_idx_s;
    logic [DATA_W-1:0]  g0_data_s;
    logic [DATA_W-1:0]  g1_data_s;
    logic               conflict_s;

    logic               write0_en_r;
    logic [PREG_W-1:0]  write0_idx_r;
    logic [DATA_W-1:0]  write0_data_r;
    logic               write1_en_r;
    logic [PREG_W-1:0]  write1_idx_r;
    logic [DATA_W-1:0]  write1_data_r;
    logic [15:0]        conflict_cnt_r;

    function automatic logic [PREG_W-1:0] idx_of(input logic [NUM_REQ*PREG_W-1:0] v, input int i);
        return v[i*PREG_W +: PREG_W];
    endfunction

    function automatic logic [DATA_W-1:0] data_of(input logic [NUM_REQ*DATA_W-1:0] v, input int i);
        return v[i*DATA_W +: DATA_W];
    endfunction

    // Split valid requests into port-consuming writes and preg-0 null writes
    always_comb begin
        eligible_s = '0;
        null_s     = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (bus.req_valid[i]) begin
                if (idx_of(bus.req_idx, i) == {PREG_W{1'b0}}) begin
                    null_s[i] = 1'b1;
                end else begin
                    eligible_s[i] = 1'b1;
                end
            end else begin
                null_s[i]     = 1'b0;
                eligible_s[i] = 1'b0;
            end
        end
    end

    // Round-robin scan from rr_ptr: first eligible takes port 0, next one with a different preg takes port 1
    always_comb begin
        int scan_j;
        int last_j;
        int nxt_j;
        scan_j       = 0;
        last_j       = 0;
        nxt_j        = 0;
        grant0_s     = '0;
        grant1_s     = '0;
        g0_found_s   = 1'b0;
        g1_found_s   = 1'b0;
        g0_idx_s     = '0;
        g1_idx_s     = '0;
        g0_data_s    = '0;
        g1_data_s    = '0;
        rr_ptr_nxt_s = rr_ptr_r;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan_j = int'(rr_ptr_r) + k;
            if (scan_j >= NUM_REQ) begin
                scan_j = scan_j - NUM_REQ;
            end else begin
                scan_j = scan_j;
            end
            if (eligible_s[scan_j]) begin
                if (!g0_found_s) begin
                    g0_found_s       = 1'b1;
                    grant0_s[scan_j] = 1'b1;
                    g0_idx_s         = idx_of(bus.req_idx, scan_j);
                    g0_data_s        = data_of(bus.req_data, scan_j);
                    last_j           = scan_j;
                end else if (!g1_found_s && (idx_of(bus.req_idx, scan_j) != g0_idx_s)) begin
                    g1_found_s       = 1'b1;
                    grant1_s[scan_j] = 1'b1;
                    g1_idx_s         = idx_of(bus.req_idx, scan_j);
                    g1_data_s        = data_of(bus.req_data, scan_j);
                    last_j           = scan_j;
                end else begin
                    // Same preg as port 0, or both ports taken: the requester waits
                    last_j = last_j;
                end
            end else begin
                last_j = last_j;
            end
        end
        if (g0_found_s) begin
            nxt_j = last_j + 1;
            if (nxt_j >= NUM_REQ) begin
                nxt_j = 0;
            end else begin
                nxt_j = nxt_j;
            end
            rr_ptr_nxt_s = PTR_W'(nxt_j);
        end else begin
            rr_ptr_nxt_s = rr_ptr_r;
        end
    end

    assign conflict_s    = |(eligible_s & ~(grant0_s | grant1_s));
    assign bus.req_ready = grant0_s | grant1_s | null_s;

    // Output stage: register the granted writes for the regfile ports
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            write0_en_r   <= 1'b0;
            write0_idx_r  <= '0;
            write0_data_r <= '0;
            write1_en_r   <= 1'b0;
            write1_idx_r  <= '0;
            write1_data_r <= '0;
        end else begin
            write0_en_r <= g0_found_s;
            write1_en_r <= g1_found_s;
            if (g0_found_s) begin
                write0_idx_r  <= g0_idx_s;
                write0_data_r <= g0_data_s;
            end
            if (g1_found_s) begin
                write1_idx_r  <= g1_idx_s;
                write1_data_r <= g1_data_s;
            end
        end
    end

    // Round-robin pointer and saturating count of cycles with a refused eligible request
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rr_ptr_r       <= '0;
            conflict_cnt_r <= 16'h0000;
        end else begin
            rr_ptr_r <= rr_ptr_nxt_s;
            if (conflict_s && (conflict_cnt_r != 16'hFFFF)) begin
                conflict_cnt_r <= conflict_cnt_r + 16'h0001;
            end
        end
    end

    assign bus.write0_en    = write0_en_r;
    assign bus.write0_idx   = write0_idx_r;
    assign bus.write0_data  = write0_data_r;
    assign bus.write1_en    = write1_en_r;
    assign bus.write1_idx   = write1_idx_r;
    assign bus.write1_data  = write1_data_r;
    assign bus.conflict_cnt = conflict_cnt_r;
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: a chained table of single-cycle
// vectors (round-robin state carries from row to row) plus a hand-written
// reset-during-pending-write sequence.
module tb_regfile_wb_arbiter;
    logic clock;
    logic reset;
    int   tests;
    int   fails;

    regfile_wb_arbiter_if #(.NUM_REQ(4), .PREG_W(6), .DATA_W(64)) bus ();

    regfile_wb_arbiter #(.NUM_REQ(4), .PREG_W(6), .DATA_W(64)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [3:0]      valid;
        logic [3:0][5:0] idx;     // {idx3, idx2, idx1, idx0}
        logic [3:0]      ready;
        int              g0;      // requester expected on port 0, -1 = none
        int              g1;      // requester expected on port 1, -1 = none
        int              rr;      // rr_ptr after the edge
        int              cnt;     // conflict_cnt after the edge
    } vec_t;

    vec_t vecs [14];

    function automatic logic [63:0] dval(input int i, input logic [5:0] idx);
        return (64'(8'hA0 + 8'(i)) << 56) | (64'(i) << 32) | 64'(idx);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [3:0] valid, input logic [3:0][5:0] idx);
        bus.req_valid = valid;
        for (int i = 0; i < 4; i++) begin
            bus.req_idx[i*6 +: 6]   = idx[i];
            bus.req_data[i*64 +: 64] = dval(i, idx[i]);
        end
    endtask

    initial begin
        logic [3:0][5:0] idx_h;
        tests = 0;
        fails = 0;

        //          valid     {idx3,  idx2,  idx1,  idx0}      ready    g0  g1  rr cnt
        vecs[0]  = '{4'b0100, {6'd0,  6'd17, 6'd0,  6'd0},  4'b0100,  2, -1, 3, 0};
        vecs[1]  = '{4'b1001, {6'd8,  6'd0,  6'd0,  6'd7},  4'b1001,  3,  0, 1, 0};
        vecs[2]  = '{4'b1000, {6'd5,  6'd0,  6'd0,  6'd0},  4'b1000,  3, -1, 0, 0};
        vecs[3]  = '{4'b1111, {6'd4,  6'd3,  6'd2,  6'd1},  4'b0011,  0,  1, 2, 1};
        vecs[4]  = '{4'b1100, {6'd4,  6'd3,  6'd0,  6'd0},  4'b1100,  2,  3, 0, 1};
        vecs[5]  = '{4'b0011, {6'd0,  6'd0,  6'd5,  6'd0},  4'b0011,  1, -1, 2, 1};
        vecs[6]  = '{4'b1000, {6'd11, 6'd0,  6'd0,  6'd0},  4'b1000,  3, -1, 0, 1};
        vecs[7]  = '{4'b0111, {6'd0,  6'd10, 6'd9,  6'd9},  4'b0101,  0,  2, 3, 2};
        vecs[8]  = '{4'b0010, {6'd0,  6'd0,  6'd9,  6'd0},  4'b0010,  1, -1, 2, 2};
        vecs[9]  = '{4'b0000, {6'd0,  6'd0,  6'd0,  6'd0},  4'b0000, -1, -1, 2, 2};
        vecs[10] = '{4'b0001, {6'd0,  6'd0,  6'd0,  6'd0},  4'b0001, -1, -1, 2, 2};
        vecs[11] = '{4'b0111, {6'd0,  6'd14, 6'd13, 6'd12}, 4'b0101,  2,  0, 1, 3};
        vecs[12] = '{4'b0010, {6'd0,  6'd0,  6'd13, 6'd0},  4'b0010,  1, -1, 2, 3};
        vecs[13] = '{4'b1111, {6'd20, 6'd20, 6'd20, 6'd20}, 4'b0100,  2, -1, 3, 4};

        // Reset state
        reset = 1'b1;
        drive(4'b0000, '0);
        repeat (2) @(posedge clock);
        #1;
        check("rst_w0_en",  64'(bus.write0_en),    64'd0);
        check("rst_w1_en",  64'(bus.write1_en),    64'd0);
        check("rst_w0_idx", 64'(bus.write0_idx),   64'd0);
        check("rst_w0_dat", bus.write0_data,       64'd0);
        check("rst_w1_dat", bus.write1_data,       64'd0);
        check("rst_cnt",    64'(bus.conflict_cnt), 64'd0);
        check("rst_rr",     64'(dut.rr_ptr_r),     64'd0);
        @(negedge clock);
        reset = 1'b0;

        // Table-driven single-cycle vectors
        for (int n = 0; n < 14; n++) begin
            @(negedge clock);
            drive(vecs[n].valid, vecs[n].idx);
            #1;
            check($sformatf("v%0d_ready", n), 64'(bus.req_ready), 64'(vecs[n].ready));
            @(posedge clock);
            #1;
            check($sformatf("v%0d_w0_en", n), 64'(bus.write0_en), 64'(vecs[n].g0 >= 0));
            check($sformatf("v%0d_w1_en", n), 64'(bus.write1_en), 64'(vecs[n].g1 >= 0));
            if (vecs[n].g0 >= 0) begin
                check($sformatf("v%0d_w0_idx", n), 64'(bus.write0_idx), 64'(vecs[n].idx[vecs[n].g0]));
                check($sformatf("v%0d_w0_dat", n), bus.write0_data, dval(vecs[n].g0, vecs[n].idx[vecs[n].g0]));
            end
            if (vecs[n].g1 >= 0) begin
                check($sformatf("v%0d_w1_idx", n), 64'(bus.write1_idx), 64'(vecs[n].idx[vecs[n].g1]));
                check($sformatf("v%0d_w1_dat", n), bus.write1_data, dval(vecs[n].g1, vecs[n].idx[vecs[n].g1]));
            end
            check($sformatf("v%0d_rr", n),  64'(dut.rr_ptr_r),     64'(vecs[n].rr));
            check($sformatf("v%0d_cnt", n), 64'(bus.conflict_cnt), 64'(vecs[n].cnt));
        end

        // Reset asserted with a write pending in the output stage
        @(negedge clock);
        drive(4'b0000, '0);
        @(negedge clock);
        idx_h = {6'd0, 6'd0, 6'd2, 6'd1};
        drive(4'b0011, idx_h);
        @(posedge clock);
        #1;
        check("pre_rst_w0_en", 64'(bus.write0_en), 64'd1);
        check("pre_rst_w1_en", 64'(bus.write1_en), 64'd1);
        #2;
        reset = 1'b1;
        #1;
        check("async_w0_en", 64'(bus.write0_en),    64'd0);
        check("async_w1_en", 64'(bus.write1_en),    64'd0);
        check("async_w0_dat", bus.write0_data,      64'd0);
        check("async_cnt",   64'(bus.conflict_cnt), 64'd0);
        check("async_rr",    64'(dut.rr_ptr_r),     64'd0);
        check("rst_ready",   64'(bus.req_ready),    64'b0011);
        @(posedge clock);
        #1;
        check("rst_hold_w0", 64'(bus.write0_en), 64'd0);
        check("rst_hold_w1", 64'(bus.write1_en), 64'd0);
        @(negedge clock);
        drive(4'b0000, '0);
        reset = 1'b0;
        @(posedge clock);
        #1;
        check("post_rst_w0", 64'(bus.write0_en),    64'd0);
        check("post_rst_rr", 64'(dut.rr_ptr_r),     64'd0);
        check("post_rst_cnt", 64'(bus.conflict_cnt), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
